// File: rtl/gc_joybus_pkg.sv
// Joybus timing constants and FSM state encoding shared by the GameCube
// command transmitter and response receiver.
package gc_joybus_pkg;

  localparam int unsigned CYC_PER_US       = 100;
  localparam int unsigned BIT_CYC          = 400;
  localparam int unsigned RESP_BITS_DEF    = 64;
  localparam int unsigned THRESH_CYC_DEF   = 200;
  localparam int unsigned LOW_MAX_CYC_DEF  = 500;
  localparam int unsigned WAIT_MAX_CYC_DEF = 10000;

  typedef logic [2:0] gc_state_t;

  localparam gc_state_t ST_IDLE      = 3'd0;
  localparam gc_state_t ST_WAIT_FALL = 3'd1;
  localparam gc_state_t ST_LOW       = 3'd2;
  localparam gc_state_t ST_STOP      = 3'd3;
  localparam gc_state_t ST_DONE      = 3'd4;
  localparam gc_state_t ST_ERR       = 3'd5;

endpackage

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the open-drain data line plus edge detection
// against a third flop; reset to the idle (pulled-high) level.
module gc_line_sync (
  input  logic clk100mhz,
  input  logic reset,
  input  logic data_in,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [2:0] sr;

  always_ff @(posedge clk100mhz) begin
    if (reset) sr <= '1;
    else       sr <= {sr[1:0], data_in};
  end

  assign level = sr[1];
  assign fall  = sr[2] & ~sr[1];
  assign rise  = ~sr[2] & sr[1];

endmodule

// File: rtl/gc_response_rx.sv
// GameCube controller reply receiver: measures low pulses on the data line,
// shifts decoded bits MSB-first, checks the stop bit and flags timeouts/framing.
module gc_response_rx
  import gc_joybus_pkg::*;
#(
  parameter int unsigned RESP_BITS    = RESP_BITS_DEF,
  parameter int unsigned THRESH_CYC   = THRESH_CYC_DEF,
  parameter int unsigned LOW_MAX_CYC  = LOW_MAX_CYC_DEF,
  parameter int unsigned WAIT_MAX_CYC = WAIT_MAX_CYC_DEF
) (
  input  logic                 clk100mhz,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 data_in,
  output logic [RESP_BITS-1:0] response,
  output logic                 valid,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_frame
);

  localparam int unsigned BIT_W  = $clog2(RESP_BITS + 1);
  localparam int unsigned WAIT_W = $clog2(WAIT_MAX_CYC + 1);

  localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(RESP_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RESP_BITS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX_CYC - 1);

  gc_state_t         state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [9:0]        low_cnt;
  logic [10:0]       low_width;
  logic              rx_bit;
  logic              line_level;
  logic              line_fall;
  logic              line_rise;

  gc_line_sync u_sync (
    .clk100mhz (clk100mhz),
    .reset     (reset),
    .data_in   (data_in),
    .level     (line_level),
    .fall      (line_fall),
    .rise      (line_rise)
  );

  // low_cnt restarts at 0 on the cycle the fall is seen, which is itself a
  // low sample, so the true low width is one more than the count.
  always_comb begin
    low_width = {1'b0, low_cnt} + 11'd1;
    rx_bit    = (low_width < 11'(THRESH_CYC));
  end

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      state       <= ST_IDLE;
      response    <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      low_cnt     <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_WAIT_FALL;
            response    <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_WAIT_FALL, ST_STOP: begin
          if (line_fall) begin
            state   <= ST_LOW;
            low_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= ST_ERR;
            err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_LOW: begin
          if (low_cnt != '1) low_cnt <= low_cnt + 10'd1;
          if (line_rise) begin
            // bit_cnt == RESP_BITS means this low pulse was the stop bit
            if (bit_cnt < BIT_FULL) begin
              response <= {response[RESP_BITS-2:0], rx_bit};
              bit_cnt  <= bit_cnt + BIT_W'(1);
              wait_cnt <= '0;
              state    <= (bit_cnt == BIT_LAST) ? ST_STOP : ST_WAIT_FALL;
            end else begin
              state <= ST_DONE;
            end
          end else if (!line_level && low_width > 11'(LOW_MAX_CYC)) begin
            state     <= ST_ERR;
            err_frame <= 1'b1;
          end
        end
        ST_DONE: begin
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_response_rx.sv
// Bench for gc_response_rx: table of reply vectors scored through an expected
// queue, plus hand-written timeout, framing, reset and stray-start sequences.
module tb_gc_response_rx;

  typedef struct {
    logic [63:0] word;
    int unsigned one_w;
    int unsigned zero_w;
    int unsigned high_w;   // 0 selects a 400-cycle bit period
    int unsigned stop_w;
  } vec_t;

  logic        clk100mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic        data_in   = 1'b1;
  logic [63:0] response;
  logic        valid;
  logic        busy;
  logic        err_timeout;
  logic        err_frame;

  int          tests     = 0;
  int          fails     = 0;
  int          valid_cnt = 0;
  logic [63:0] exp_q[$];
  vec_t        vecs[4];

  always #5 clk100mhz = ~clk100mhz;

  gc_response_rx #(
    .RESP_BITS    (64),
    .THRESH_CYC   (200),
    .LOW_MAX_CYC  (500),
    .WAIT_MAX_CYC (10000)
  ) dut (
    .clk100mhz   (clk100mhz),
    .reset       (reset),
    .start       (start),
    .data_in     (data_in),
    .response    (response),
    .valid       (valid),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_frame   (err_frame)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid strobe must match the oldest queued reply.
  always @(negedge clk100mhz) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
      else check("sb_response", response, exp_q.pop_front());
      check("busy_at_valid", {63'd0, busy}, 64'd0);
    end
  end

  initial begin
    #1500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic arm();
    @(negedge clk100mhz);
    start = 1'b1;
    @(negedge clk100mhz);
    start = 1'b0;
  endtask

  task automatic drive_bit(input int unsigned low, input int unsigned high, input bit pulse);
    for (int unsigned j = 0; j < low; j++) begin
      @(negedge clk100mhz);
      data_in = 1'b0;
      start   = pulse && (j == 0);
    end
    for (int unsigned j = 0; j < high; j++) begin
      @(negedge clk100mhz);
      data_in = 1'b1;
      start   = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [63:0] word, input int first, input int count,
                           input int unsigned one_w, input int unsigned zero_w,
                           input int unsigned high_w, input int unsigned stop_w, input int sab);
    int unsigned lw;
    int unsigned hw;
    for (int i = first; i < first + count; i++) begin
      lw = word[63-i] ? one_w : zero_w;
      hw = (high_w == 0) ? 400 - lw : high_w;
      drive_bit(lw, hw, i == sab);
    end
    if (stop_w != 0) drive_bit(stop_w, 20, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int sab, input string name);
    int n0;
    n0 = valid_cnt;
    exp_q.push_back(v.word);
    arm();
    send_bits(v.word, 0, 64, v.one_w, v.zero_w, v.high_w, v.stop_w, sab);
    for (int k = 0; k < 60 && valid_cnt == n0; k++) @(negedge clk100mhz);
    check({name, "_valid_pulses"}, 64'(valid_cnt - n0), 64'd1);
    check({name, "_errors"}, {62'd0, err_timeout, err_frame}, 64'd0);
    check({name, "_response"}, response, v.word);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n0;
    int k;

    vecs[0] = '{64'h0080808080800000, 100, 300, 0, 200};
    vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 20, 250, 10, 1};
    vecs[2] = '{64'hAAAAAAAAAAAAAAAA, 199, 200, 10, 30};
    vecs[3] = '{64'hFFFFFFFFFFFF0F0F, 20, 250, 10, 500};

    repeat (3) @(negedge clk100mhz);
    check("reset_outputs", {59'd0, valid, busy, err_timeout, err_frame, 1'b0}, 64'd0);
    check("reset_response", response, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk100mhz);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], -1, $sformatf("vec%0d", i));

    // No line activity after arming: timeout on the 10000th cycle.
    n0 = valid_cnt;
    arm();
    check("arm_busy", {63'd0, busy}, 64'd1);
    k = 0;
    while (k < 10100 && err_timeout !== 1'b1) begin
      @(negedge clk100mhz);
      k++;
    end
    check("timeout_cycle", 64'(k), 64'd10000);
    @(negedge clk100mhz);
    check("timeout_busy", {63'd0, busy}, 64'd0);
    check("timeout_no_valid", 64'(valid_cnt - n0), 64'd0);

    // Bit 5 held low 600 cycles: framing error, partial response kept.
    n0 = valid_cnt;
    arm();
    check("rearm_clears_timeout", {63'd0, err_timeout}, 64'd0);
    send_bits(64'hF800000000000000, 0, 5, 20, 250, 10, 0, -1);
    drive_bit(600, 10, 1'b0);
    check("frame_flags", {62'd0, err_timeout, err_frame}, 64'd1);
    check("frame_busy", {63'd0, busy}, 64'd0);
    check("frame_partial", response, 64'h1F);
    check("frame_no_valid", 64'(valid_cnt - n0), 64'd0);
    arm();
    check("rearm_clears_frame", {63'd0, err_frame}, 64'd0);
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    send_bits(64'hFFFFFFFFFFFFFFFF, 0, 64, 20, 250, 10, 5, -1);
    for (int j = 0; j < 60 && valid_cnt == n0; j++) @(negedge clk100mhz);
    check("after_frame_valid_pulses", 64'(valid_cnt - n0), 64'd1);

    // Reset after 30 bits: outputs cleared, rest of the reply ignored.
    n0 = valid_cnt;
    arm();
    send_bits(64'hFFFFFFFFFFFFFFFF, 0, 30, 20, 250, 10, 0, -1);
    check("partial_30", response, 64'h3FFFFFFF);
    @(negedge clk100mhz);
    reset = 1'b1;
    @(negedge clk100mhz);
    reset = 1'b0;
    check("midreset_outputs", {60'd0, valid, busy, err_timeout, err_frame}, 64'd0);
    check("midreset_response", response, 64'd0);
    send_bits(64'hFFFFFFFFFFFFFFFF, 30, 34, 20, 250, 10, 5, -1);
    repeat (10) @(negedge clk100mhz);
    check("ignored_rest_no_valid", 64'(valid_cnt - n0), 64'd0);
    check("ignored_rest_state", {62'd0, busy, valid}, 64'd0);
    run_vec('{64'h123456789ABCDEF0, 20, 210, 10, 20}, -1, "after_reset");

    // Start coincident with reset is ignored; a stray start mid-reply too.
    @(negedge clk100mhz);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk100mhz);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk100mhz);
    check("reset_start_busy", {63'd0, busy}, 64'd0);
    run_vec('{64'h0080808080800000, 20, 200, 10, 200}, 10, "stray_start");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
